// File: rtl/spike_rate_decoder_if.sv
// Result/control bundle for the spike rate decoder.
// The master side drives the enable, window length, spike lines and result
// ready. The slave side (the decoder) returns the windowed result and status.
interface spike_rate_decoder_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 10
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    en;
  logic [WIN_W-1:0]        win_len;
  logic [NUM_CH-1:0]       spike_in;
  logic                    res_ready;
  logic                    res_valid;
  logic [NUM_CH*CNT_W-1:0] res_counts;
  logic [IDX_W-1:0]        res_max_ch;
  logic                    overrun;
  logic                    busy;

  modport master (
    output en, win_len, spike_in, res_ready,
    input  res_valid, res_counts, res_max_ch, overrun, busy
  );

  modport slave (
    input  en, win_len, spike_in, res_ready,
    output res_valid, res_counts, res_max_ch, overrun, busy
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts rising edges on each spike line over a
// programmable window, then presents per-channel counts and the index of the
// busiest channel on a valid/ready result port. Windows run back-to-back
// while enabled; an unconsumed result that gets replaced sets a sticky
// overrun flag.
module spike_rate_decoder #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int WIN_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  spike_rate_decoder_if.slave bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]              state;
  logic [WIN_W-1:0]        win_cnt;
  logic [NUM_CH-1:0]       spike_prev;
  logic [NUM_CH-1:0]       events;
  logic [CNT_W-1:0]        cnt [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] final_counts;
  logic                    win_end;
  logic                    start_ok;
  logic                    xfer;
  logic                    result_valid;
  logic [NUM_CH*CNT_W-1:0] result_counts;
  logic [IDX_W-1:0]        result_max;
  logic                    overrun_flag;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic ev);
    if (ev && (c != CNT_MAX)) return c + 1'b1;
    return c;
  endfunction

  // Index of the largest count; strict compare keeps the lowest index on ties.
  function automatic logic [IDX_W-1:0] arg_max(input logic [NUM_CH*CNT_W-1:0] v);
    logic [CNT_W-1:0] best;
    logic [IDX_W-1:0] idx;
    best = v[CNT_W-1:0];
    idx  = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (v[i*CNT_W +: CNT_W] > best) begin
        best = v[i*CNT_W +: CNT_W];
        idx  = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Rising-edge events and the counts as they stand after this cycle's events.
  always_comb begin
    events       = bus.spike_in & ~spike_prev;
    final_counts = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      final_counts[i*CNT_W +: CNT_W] = sat_inc(cnt[i], events[i]);
    end
  end

  // Abort (en low) outranks the window end, so window end requires en.
  assign win_end  = (state == ST_COUNT) && bus.en && (win_cnt == '0);
  assign start_ok = bus.en && (bus.win_len != '0);
  assign xfer     = result_valid && bus.res_ready;

  // Spike history for edge detection, tracked in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) spike_prev <= '0;
    else     spike_prev <= bus.spike_in;
  end

  // Window FSM and per-channel counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      win_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state   <= ST_COUNT;
            win_cnt <= bus.win_len - 1'b1;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
          end
        end
        ST_COUNT: begin
          if (!bus.en) begin
            // Partial window is dropped.
            state <= ST_IDLE;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
          end else if (win_cnt == '0) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            if (bus.win_len != '0) win_cnt <= bus.win_len - 1'b1;
            else                   state   <= ST_IDLE;
          end else begin
            win_cnt <= win_cnt - 1'b1;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= final_counts[i*CNT_W +: CNT_W];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result registers, valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid  <= 1'b0;
      result_counts <= '0;
      result_max    <= '0;
      overrun_flag  <= 1'b0;
    end else if (win_end) begin
      result_counts <= final_counts;
      result_max    <= arg_max(final_counts);
      result_valid  <= 1'b1;
      if (result_valid && !bus.res_ready) overrun_flag <= 1'b1;
    end else if (xfer) begin
      result_valid <= 1'b0;
    end
  end

  assign bus.res_valid  = result_valid;
  assign bus.res_counts = result_counts;
  assign bus.res_max_ch = result_max;
  assign bus.overrun    = overrun_flag;
  assign bus.busy       = (state == ST_COUNT);
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a table of single windows plus
// hand-written sequences for saturation, overrun, abort and async reset.
module tb_spike_rate_decoder;
  logic clk;
  logic rst;

  spike_rate_decoder_if #(.NUM_CH(4), .CNT_W(8), .WIN_W(10)) bus ();

  spike_rate_decoder #(.NUM_CH(4), .CNT_W(8), .WIN_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  wl;   // window length
    logic [3:0]  st;   // spike level during the start (IDLE) cycle
    logic [63:0] pat;  // nibble k = spike_in in COUNT cycle k
    logic [31:0] exp;  // {ch3, ch2, ch1, ch0} expected counts
    logic [1:0]  mx;   // expected winner index
  } vec_t;

  vec_t vecs [6];
  int   total  = 0;
  int   passed = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  initial begin
    // ch0 pulses in cycles 1,3,5
    vecs[0] = '{wl: 10'd8, st: 4'h0, pat: 64'h0000000000101010, exp: 32'h00000003, mx: 2'd0};
    // ch2 held 5 cycles, ch1 two pulses
    vecs[1] = '{wl: 10'd8, st: 4'h0, pat: 64'h0000000002444640, exp: 32'h00010200, mx: 2'd1};
    // ch1 = ch2 = 2 tie
    vecs[2] = '{wl: 10'd8, st: 4'h0, pat: 64'h0000000040402020, exp: 32'h00020200, mx: 2'd1};
    // ch3 already high on entry, ch0 one pulse
    vecs[3] = '{wl: 10'd4, st: 4'h8, pat: 64'h0000000000008988, exp: 32'h00000001, mx: 2'd0};
    // one-cycle window, all channels tie
    vecs[4] = '{wl: 10'd1, st: 4'h0, pat: 64'h000000000000000F, exp: 32'h01010101, mx: 2'd0};
    // edge only in the last window cycle
    vecs[5] = '{wl: 10'd3, st: 4'h0, pat: 64'h0000000000000800, exp: 32'h01000000, mx: 2'd3};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.win_len = '0;
    bus.spike_in = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid",   64'(bus.res_valid),  64'd0);
    chk("rst_counts",  64'(bus.res_counts), 64'd0);
    chk("rst_max",     64'(bus.res_max_ch), 64'd0);
    chk("rst_overrun", 64'(bus.overrun),    64'd0);
    chk("rst_busy",    64'(bus.busy),       64'd0);
    rst = 1'b0;
    tick();

    // Table of single windows, each ending in IDLE via win_len=0 in its last cycle.
    for (int v = 0; v < 6; v++) begin
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk($sformatf("v%0d_pre_valid", v), 64'(bus.res_valid), 64'd0);
      bus.en = 1'b1;
      bus.win_len = vecs[v].wl;
      bus.spike_in = vecs[v].st;
      tick();
      chk($sformatf("v%0d_busy", v), 64'(bus.busy), 64'd1);
      for (int k = 0; k < int'(vecs[v].wl); k++) begin
        bus.spike_in = vecs[v].pat[k*4 +: 4];
        if (k == int'(vecs[v].wl) - 1) bus.win_len = '0;
        tick();
      end
      chk($sformatf("v%0d_valid", v),  64'(bus.res_valid),  64'd1);
      chk($sformatf("v%0d_counts", v), 64'(bus.res_counts), 64'(vecs[v].exp));
      chk($sformatf("v%0d_max", v),    64'(bus.res_max_ch), 64'(vecs[v].mx));
      chk($sformatf("v%0d_idle", v),   64'(bus.busy),       64'd0);
      bus.en = 1'b0;
      bus.spike_in = '0;
      tick();
    end

    // Saturation: 300 edges on ch3 in a 600-cycle window.
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    bus.en = 1'b1;
    bus.win_len = 10'd600;
    bus.spike_in = '0;
    tick();
    for (int k = 0; k < 600; k++) begin
      bus.spike_in = (k % 2 == 0) ? 4'h8 : 4'h0;
      if (k == 599) bus.win_len = '0;
      tick();
    end
    chk("sat_valid",  64'(bus.res_valid),  64'd1);
    chk("sat_counts", 64'(bus.res_counts), 64'h00000000FF000000);
    chk("sat_max",    64'(bus.res_max_ch), 64'd3);
    bus.en = 1'b0;
    bus.spike_in = '0;
    tick();

    // Overrun: fresh reset, three back-to-back 4-cycle windows.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b0;
    bus.en = 1'b1;
    bus.win_len = 10'd4;
    bus.spike_in = '0;
    tick();
    // W1: ch0 pulse
    bus.spike_in = 4'h0; tick();
    bus.spike_in = 4'h1; tick();
    bus.spike_in = 4'h0; tick();
    bus.spike_in = 4'h0; tick();
    chk("w1_valid",   64'(bus.res_valid),  64'd1);
    chk("w1_counts",  64'(bus.res_counts), 64'h0000000000000001);
    // W2: ch1 pulse, transfer coincides with window end
    bus.spike_in = 4'h0; tick();
    bus.spike_in = 4'h2; tick();
    bus.spike_in = 4'h0; tick();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("w2_valid",   64'(bus.res_valid),  64'd1);
    chk("w2_overrun", 64'(bus.overrun),    64'd0);
    chk("w2_counts",  64'(bus.res_counts), 64'h0000000000000100);
    chk("w2_max",     64'(bus.res_max_ch), 64'd1);
    // W3: ch2 two pulses, result not taken
    bus.spike_in = 4'h4; tick();
    bus.spike_in = 4'h0; tick();
    bus.spike_in = 4'h4; tick();
    bus.spike_in = 4'h0;
    bus.win_len = '0;
    tick();
    chk("w3_valid",   64'(bus.res_valid),  64'd1);
    chk("w3_overrun", 64'(bus.overrun),    64'd1);
    chk("w3_counts",  64'(bus.res_counts), 64'h0000000000020000);
    chk("w3_max",     64'(bus.res_max_ch), 64'd2);
    bus.en = 1'b0;
    tick();
    chk("hold_valid", 64'(bus.res_valid),  64'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("xfer_valid",   64'(bus.res_valid), 64'd0);
    chk("xfer_overrun", 64'(bus.overrun),   64'd1);

    // Abort: en drops in the 4th cycle of a 10-cycle window.
    begin
      logic rose;
      bus.en = 1'b1;
      bus.win_len = 10'd10;
      bus.spike_in = '0;
      tick();
      bus.spike_in = 4'h1; tick();
      bus.spike_in = 4'h0; tick();
      bus.spike_in = 4'h1; tick();
      bus.en = 1'b0;
      bus.spike_in = 4'h0;
      tick();
      chk("abort_busy", 64'(bus.busy), 64'd0);
      rose = 1'b0;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (bus.res_valid) rose = 1'b1;
      end
      chk("abort_no_valid", 64'(rose), 64'd0);
      // win_len = 0 never starts a window
      bus.en = 1'b1;
      bus.win_len = '0;
      rose = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (bus.busy || bus.res_valid) rose = 1'b1;
      end
      chk("zero_len_idle", 64'(rose), 64'd0);
    end

    // Async reset mid-window while a result is pending.
    bus.res_ready = 1'b0;
    bus.en = 1'b1;
    bus.win_len = 10'd3;
    bus.spike_in = '0;
    tick();
    bus.spike_in = 4'h1; tick();
    bus.spike_in = 4'h0; tick();
    bus.win_len = 10'd5;
    tick();
    chk("pre_rst_valid",  64'(bus.res_valid),  64'd1);
    chk("pre_rst_counts", 64'(bus.res_counts), 64'h0000000000000001);
    chk("pre_rst_busy",   64'(bus.busy),       64'd1);
    bus.spike_in = 4'h2;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_valid",   64'(bus.res_valid),  64'd0);
    chk("arst_counts",  64'(bus.res_counts), 64'd0);
    chk("arst_max",     64'(bus.res_max_ch), 64'd0);
    chk("arst_overrun", 64'(bus.overrun),    64'd0);
    chk("arst_busy",    64'(bus.busy),       64'd0);
    bus.en = 1'b0;
    bus.spike_in = '0;
    tick();
    rst = 1'b0;
    tick();
    bus.en = 1'b1;
    bus.win_len = 10'd2;
    tick();
    bus.spike_in = 4'h2; tick();
    bus.spike_in = 4'h0;
    bus.win_len = '0;
    tick();
    chk("restart_valid",  64'(bus.res_valid),  64'd1);
    chk("restart_counts", 64'(bus.res_counts), 64'h0000000000000100);
    chk("restart_max",    64'(bus.res_max_ch), 64'd1);
    bus.en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
